// File: rtl/kmeans_pkg.sv
// Shared definitions for the K=2, D=4 k-means pass controller:
// FSM encoding, geometry constants and bus packing offsets.
package kmeans_pkg;

    localparam int unsigned K            = 2;
    localparam int unsigned D            = 4;
    localparam int unsigned PIPE_LATENCY = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // LSB of dimension d within a packed sample bus of element width w.
    function automatic int unsigned samp_lsb(input int unsigned d, input int unsigned w);
        return d * w;
    endfunction

    // LSB of centroid k, dimension d within the packed centroid bus; k0d0 at bit 0.
    function automatic int unsigned cent_lsb(input int unsigned k, input int unsigned d,
                                             input int unsigned w);
        return (k * D + d) * w;
    endfunction

endpackage

// File: rtl/kmeans_acc_bank.sv
// Per-centroid per-dimension sum and count accumulators with a combinational read mux.
module kmeans_acc_bank
    import kmeans_pkg::*;
#(
    parameter int input_data_width = 16,
    parameter int cnt_width        = 16,
    localparam int W = input_data_width,
    localparam int C = cnt_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sel,
    input  logic [D*W-1:0]   data,
    input  logic             rd_k,
    input  logic [1:0]       rd_d,
    output logic [W+C-1:0]   rd_sum,
    output logic [C-1:0]     rd_cnt
);

    logic [W+C-1:0] sum_q [K][D];
    logic [C-1:0]   cnt_q [K];

    // clr wins over en so a new pass always starts from zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int unsigned k = 0; k < K; k++) begin
                cnt_q[k] <= '0;
                for (int unsigned d = 0; d < D; d++) begin
                    sum_q[k][d] <= '0;
                end
            end
        end else if (en) begin
            for (int unsigned d = 0; d < D; d++) begin
                sum_q[sel][d] <= sum_q[sel][d] + {{C{1'b0}}, data[samp_lsb(d, W) +: W]};
            end
            cnt_q[sel] <= cnt_q[sel] + 1'b1;
        end
    end

    assign rd_sum = sum_q[rd_k][rd_d];
    assign rd_cnt = cnt_q[rd_k];

endmodule

// File: rtl/kmeans_pass_ctrl_k2_d4.sv
// Sequences one k-means assignment pass: holds centroids, streams samples into the
// external distance pipeline and accumulates the returned assignments.
module kmeans_pass_ctrl_k2_d4
    import kmeans_pkg::*;
#(
    parameter int input_data_width = 16,
    parameter int cnt_width        = 16,
    parameter int pipe_latency     = PIPE_LATENCY,
    localparam int W = input_data_width,
    localparam int C = cnt_width
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [C-1:0]       num_points,
    input  logic               cfg_we,
    input  logic               cfg_k,
    input  logic [1:0]         cfg_d,
    input  logic [W-1:0]       cfg_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [D*W-1:0]     s_data,
    output logic [K*D*W-1:0]   pipe_centroid,
    output logic [D*W-1:0]     pipe_data,
    input  logic [D*W-1:0]     pipe_out_data,
    input  logic               pipe_sel,
    output logic               busy,
    output logic               done,
    input  logic               rd_k,
    input  logic [1:0]         rd_d,
    output logic [W+C-1:0]     rd_sum,
    output logic [C-1:0]       rd_cnt
);

    state_t                  state;
    logic [C-1:0]            npts;
    logic [C-1:0]            issued;
    logic [pipe_latency-1:0] vld_sr;
    logic [W-1:0]            cent [K][D];
    logic                    accept;
    logic                    acc_clr;

    assign s_ready = (state == ST_RUN) && (issued != npts);
    assign accept  = s_valid && s_ready;
    assign acc_clr = (state == ST_IDLE) && start;

    always_comb begin
        pipe_centroid = '0;
        for (int unsigned k = 0; k < K; k++) begin
            for (int unsigned d = 0; d < D; d++) begin
                pipe_centroid[cent_lsb(k, d, W) +: W] = cent[k][d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            npts      <= '0;
            issued    <= '0;
            vld_sr    <= '0;
            pipe_data <= '0;
            for (int unsigned k = 0; k < K; k++) begin
                for (int unsigned d = 0; d < D; d++) begin
                    cent[k][d] <= '0;
                end
            end
        end else begin
            vld_sr <= {vld_sr[pipe_latency-2:0], accept};
            if (accept) begin
                pipe_data <= s_data;
                issued    <= issued + 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    // The write lands in the same edge as start, so the pass sees it.
                    if (cfg_we) begin
                        cent[cfg_k][cfg_d] <= cfg_data;
                    end
                    if (start) begin
                        npts   <= num_points;
                        issued <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issued == npts) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (vld_sr == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    kmeans_acc_bank #(
        .input_data_width (W),
        .cnt_width        (C)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (vld_sr[pipe_latency-1]),
        .sel    (pipe_sel),
        .data   (pipe_out_data),
        .rd_k   (rd_k),
        .rd_d   (rd_d),
        .rd_sum (rd_sum),
        .rd_cnt (rd_cnt)
    );

endmodule

// File: tb/tb_kmeans_pass_ctrl_k2_d4.sv
// Bench for kmeans_pass_ctrl_k2_d4: wraps it with a K=2 D=4 distance pipeline and
// checks every cycle against a pass-level reference model.
module tb_kmeans_pass_ctrl_k2_d4;

    localparam int W = 16;
    localparam int C = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, cfg_we, cfg_k, s_valid, s_ready, pipe_sel, busy, done, rd_k;
    logic [C-1:0]   num_points, rd_cnt;
    logic [1:0]     cfg_d, rd_d;
    logic [W-1:0]   cfg_data;
    logic [4*W-1:0] s_data, pipe_data, pipe_out_data;
    logic [8*W-1:0] pipe_centroid;
    logic [W+C-1:0] rd_sum;

    int checks = 0;
    int errors = 0;

    kmeans_pass_ctrl_k2_d4 #(
        .input_data_width (W),
        .cnt_width        (C),
        .pipe_latency     (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_points    (num_points),
        .cfg_we        (cfg_we),
        .cfg_k         (cfg_k),
        .cfg_d         (cfg_d),
        .cfg_data      (cfg_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .pipe_centroid (pipe_centroid),
        .pipe_data     (pipe_data),
        .pipe_out_data (pipe_out_data),
        .pipe_sel      (pipe_sel),
        .busy          (busy),
        .done          (done),
        .rd_k          (rd_k),
        .rd_d          (rd_d),
        .rd_sum        (rd_sum),
        .rd_cnt        (rd_cnt)
    );

    // Squared-distance nearest centroid; a tie goes to centroid 1.
    function automatic logic nearest(input logic [4*W-1:0] x, input logic [8*W-1:0] cb);
        longint d0 = 0, d1 = 0, e;
        for (int d = 0; d < 4; d++) begin
            e  = longint'(x[d*W +: W]) - longint'(cb[d*W +: W]);
            d0 += e * e;
            e  = longint'(x[d*W +: W]) - longint'(cb[(4+d)*W +: W]);
            d1 += e * e;
        end
        return (d1 <= d0);
    endfunction

    // Distance pipeline: sample registered by the DUT returns 4 cycles later with its label.
    logic [4*W-1:0] pipe_q [4];
    always @(posedge clk) begin
        pipe_q[0] <= pipe_data;
        for (int i = 1; i < 4; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign pipe_out_data = pipe_q[3];
    assign pipe_sel      = nearest(pipe_out_data, pipe_centroid);

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state, written only by the compare process.
    int             cyc = 0;
    bit             chk_en = 0;
    bit             active = 0;
    int             start_cyc = 0, done_cyc = -1, m_npts = 0, m_issued = 0;
    logic [W-1:0]   m_cent [2][4];
    longint         m_sum [2][4];
    int             m_cnt [2];
    logic [4*W-1:0] m_last;
    bit             m_last_vld = 0;
    int             done_pulses = 0, done_seen_cyc = 0, last_acc_cyc = 0;

    task automatic model_clear_acc();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            for (int d = 0; d < 4; d++) m_sum[k][d] = 0;
        end
    endtask

    always @(negedge clk) begin : cmp
        bit             in_pass, exp_ready, acc;
        logic           ksel;
        logic [8*W-1:0] cb;
        cyc++;
        in_pass   = active && (cyc > start_cyc);
        exp_ready = in_pass && (m_issued < m_npts);
        if (chk_en) begin
            check("s_ready", s_ready, exp_ready);
            check("busy", busy, in_pass);
            check("done", done, in_pass && (cyc == done_cyc));
            for (int k = 0; k < 2; k++)
                for (int d = 0; d < 4; d++)
                    check("pipe_centroid", pipe_centroid[(k*4+d)*W +: W], m_cent[k][d]);
            if (m_last_vld) check("pipe_data", pipe_data, m_last);
            if (!in_pass) begin
                check("rd_sum", rd_sum, m_sum[rd_k][rd_d]);
                check("rd_cnt", rd_cnt, m_cnt[rd_k]);
            end
        end
        if (done === 1'b1) begin
            done_pulses++;
            done_seen_cyc = cyc;
        end
        acc = s_valid && exp_ready;
        if (acc) begin
            for (int k = 0; k < 2; k++)
                for (int d = 0; d < 4; d++) cb[(k*4+d)*W +: W] = m_cent[k][d];
            ksel = nearest(s_data, cb);
            for (int d = 0; d < 4; d++) m_sum[ksel][d] += longint'(s_data[d*W +: W]);
            m_cnt[ksel]++;
            m_issued++;
            m_last       = s_data;
            m_last_vld   = 1;
            last_acc_cyc = cyc;
            if (m_issued == m_npts) done_cyc = cyc + 7;
        end
        if (in_pass && cyc == done_cyc) active = 0;
        if (!in_pass) begin
            if (cfg_we) m_cent[cfg_k][cfg_d] = cfg_data;
            if (start) begin
                active    = 1;
                start_cyc = cyc;
                m_npts    = int'(num_points);
                m_issued  = 0;
                done_cyc  = (num_points == 0) ? cyc + 3 : -1;
                model_clear_acc();
            end
        end
        if (rst) begin
            active     = 0;
            done_cyc   = -1;
            m_npts     = 0;
            m_issued   = 0;
            m_last_vld = 0;
            model_clear_acc();
            for (int k = 0; k < 2; k++)
                for (int d = 0; d < 4; d++) m_cent[k][d] = '0;
            chk_en = 1;
        end
    end

    // Stimulus
    logic [4*W-1:0] samp [$];

    function automatic logic [4*W-1:0] rep4(input logic [W-1:0] v);
        return {v, v, v, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int k, input int d, input int v);
        cfg_we   = 1'b1;
        cfg_k    = k[0];
        cfg_d    = d[1:0];
        cfg_data = v[W-1:0];
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input int k, input int d, output longint s, output longint c);
        rd_k = k[0];
        rd_d = d[1:0];
        @(negedge clk);
        s = longint'(rd_sum);
        c = longint'(rd_cnt);
        tick();
    endtask

    task automatic sweep();
        longint s, c;
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 4; d++) rd(k, d, s, c);
    endtask

    // Streams samp[0..n-1]; optionally stalls randomly and pokes cfg_we/start mid-run.
    task automatic run_pass(input int n, input bit stall, input bit disturb);
        int  idx = 0, budget = 0;
        bit  got = 0, poked = 0;
        num_points = n[C-1:0];
        start      = 1'b1;
        tick();
        start = 1'b0;
        while (idx < n && budget < 3000) begin
            s_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = samp[idx];
            if (disturb && !poked && idx == n / 2) begin
                poked      = 1;
                cfg_we     = 1'b1;
                cfg_k      = 1'b0;
                cfg_d      = 2'd0;
                cfg_data   = 16'd999;
                start      = 1'b1;
                num_points = 16'd50;
            end
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            tick();
            cfg_we = 1'b0;
            start  = 1'b0;
            budget++;
        end
        s_valid = 1'b0;
        if (idx < n) check("feed_timeout", idx, n);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        if (!got) check("done_timeout", 0, 1);
        tick();
    endtask

    initial begin
        longint s, c, s2, c2;
        int     dp;
        rst = 1'b1; start = 1'b0; num_points = '0; cfg_we = 1'b0; cfg_k = 1'b0;
        cfg_d = '0; cfg_data = '0; s_valid = 1'b0; s_data = '0; rd_k = 1'b0; rd_d = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // 1) Basic pass, no stalls
        for (int d = 0; d < 4; d++) begin
            cfg_write(0, d, 0);
            cfg_write(1, d, 10);
        end
        samp = {rep4(16'd1), rep4(16'd9), rep4(16'd2)};
        run_pass(3, 0, 0);
        check("t1_done_latency", done_seen_cyc - last_acc_cyc, 7);
        rd(0, 0, s, c);  check("t1_sum0", s, 3);  check("t1_cnt0", c, 2);
        rd(1, 3, s, c);  check("t1_sum1", s, 9);  check("t1_cnt1", c, 1);
        sweep();

        // 2) Equidistant point goes to centroid 1
        samp = {rep4(16'd5)};
        run_pass(1, 0, 0);
        rd(1, 2, s, c);  check("t2_sum1", s, 5);  check("t2_cnt1", c, 1);
        rd(0, 0, s, c);  check("t2_cnt0", c, 0);

        // 3) Empty pass
        samp.delete();
        run_pass(0, 0, 0);
        check("t3_done_within_3", (done_seen_cyc - start_cyc) <= 3, 1);
        rd(0, 1, s, c);  check("t3_sum0", s, 0);  check("t3_cnt0", c, 0);
        rd(1, 1, s, c);  check("t3_sum1", s, 0);  check("t3_cnt1", c, 0);

        // 4) 100 random points with random stalls
        samp.delete();
        for (int i = 0; i < 100; i++)
            samp.push_back({16'($urandom_range(0, 20)), 16'($urandom_range(0, 20)),
                            16'($urandom_range(0, 20)), 16'($urandom_range(0, 20))});
        run_pass(100, 1, 0);
        sweep();
        rd(0, 0, s, c);
        rd(1, 0, s2, c2);
        check("t4_cnt_total", c + c2, 100);

        // 5) Config write and start during RUN are ignored
        samp.delete();
        for (int i = 0; i < 8; i++) samp.push_back({16'($urandom), 16'($urandom),
                                                    16'($urandom), 16'($urandom)});
        dp = done_pulses;
        run_pass(8, 1, 1);
        repeat (10) tick();
        check("t5_single_done", done_pulses - dp, 1);
        check("t5_c0d0_frozen", pipe_centroid[W-1:0], 0);
        sweep();

        // 6) Reset in DRAIN aborts the pass
        samp = {rep4(16'd1), rep4(16'd9), rep4(16'd2)};
        num_points = 16'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = samp[i];
            tick();
        end
        s_valid = 1'b0;
        repeat (2) tick();
        dp  = done_pulses;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy_after_rst", busy, 0);
        tick();
        repeat (12) tick();
        check("t6_no_done", done_pulses - dp, 0);
        rd(1, 0, s, c);  check("t6_sum1", s, 0);  check("t6_cnt1", c, 0);
        rd(0, 0, s, c);  check("t6_sum0", s, 0);  check("t6_cnt0", c, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
